alu_req_scheduler: RTL and testbench

Round-robin scheduler that shares one ALU instance between two requesters. It accepts operations over a valid/ready request channel and drives the ALU input bus with a full operand pair. It waits a fixed command-dependent latency, captures the result and flags, and returns them on a single tagged response channel. It sits between the requester logic and the ALU, on the ALU's input side.

---
 rtl/alu_req_scheduler.sv | 173 +++++++++++++++++
 tb/tb_alu_req_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_scheduler.sv
// alu_req_scheduler
// Round-robin scheduler that shares one ALU between two requesters. A request
// is accepted over a per-requester valid/ready channel and its operands are
// registered. They are presented to the ALU for one issue cycle and then held
// while a command-dependent latency elapses. The ALU result and flags are then
// captured and returned on a single response channel tagged with the
// requester index.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready      per-requester handshake (bit i = requester i)
//   req_opa/opb/cmd/mode/cin per-requester operation fields (slice i)
//   rsp_valid/rsp_ready      response handshake
//   rsp_id/rsp_res/rsp_flags requester tag, captured result and flags
//   alu_opa/opb/cmd/mode/cin ALU operation bus
//   alu_ce, alu_inp_valid    ALU clock enable and operand-valid bits
//   alu_res, alu_flags       ALU result {WIDTH+1} and {oflow,cout,g,l,e,err}
//   busy                     high whenever the scheduler is not idle
module alu_req_scheduler #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CMD_WIDTH = 4,
  parameter int unsigned LAT       = 1,
  parameter int unsigned LAT_MUL   = 2,
  parameter int unsigned MUL_CMD_A = 9,
  parameter int unsigned MUL_CMD_B = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [2*WIDTH-1:0]     req_opa,
  input  logic [2*WIDTH-1:0]     req_opb,
  input  logic [2*CMD_WIDTH-1:0] req_cmd,
  input  logic [1:0]             req_mode,
  input  logic [1:0]             req_cin,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_id,
  output logic [WIDTH:0]         rsp_res,
  output logic [5:0]             rsp_flags,
  output logic [WIDTH-1:0]       alu_opa,
  output logic [WIDTH-1:0]       alu_opb,
  output logic [CMD_WIDTH-1:0]   alu_cmd,
  output logic                   alu_mode,
  output logic                   alu_cin,
  output logic                   alu_ce,
  output logic [1:0]             alu_inp_valid,
  input  logic [WIDTH:0]         alu_res,
  input  logic [5:0]             alu_flags,
  output logic                   busy
);

  localparam int unsigned LAT_MAX = (LAT > LAT_MUL) ? LAT : LAT_MUL;
  localparam int unsigned CNT_W   = $clog2(LAT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic                 last_grant_q;
  logic                 id_q;
  logic [WIDTH-1:0]     opa_q, opb_q;
  logic [CMD_WIDTH-1:0] cmd_q;
  logic                 mode_q, cin_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIDTH:0]       res_q;
  logic [5:0]           flags_q;

  logic [1:0]           arb_ready;
  logic                 accept;
  logic                 gnt_idx;
  logic                 is_mul;
  logic [CNT_W-1:0]     lat_load;
  logic                 last_wait;
  logic                 capture;

  // Arbitration: a lone requester always wins; on contention the requester
  // that was not granted last time wins.
  always_comb begin
    arb_ready = '0;
    case (req_valid)
      2'b01:   arb_ready = 2'b01;
      2'b10:   arb_ready = 2'b10;
      2'b11:   arb_ready = last_grant_q ? 2'b01 : 2'b10;
      default: arb_ready = '0;
    endcase
  end

  // Reset is folded in so req_ready reads 0 for the whole time reset is held,
  // even though the state register then sits in IDLE.
  assign req_ready = (rst && (state_q == S_IDLE)) ? arb_ready : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign gnt_idx   = req_ready[1];

  assign is_mul   = mode_q && ((cmd_q == CMD_WIDTH'(MUL_CMD_A)) ||
                               (cmd_q == CMD_WIDTH'(MUL_CMD_B)));
  assign lat_load = is_mul ? CNT_W'(LAT_MUL) : CNT_W'(LAT);

  assign last_wait = (cnt_q == CNT_W'(1));
  assign capture   = (state_q == S_WAIT) && last_wait;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (last_wait) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      opa_q        <= '0;
      opb_q        <= '0;
      cmd_q        <= '0;
      mode_q       <= 1'b0;
      cin_q        <= 1'b0;
      cnt_q        <= '0;
      res_q        <= '0;
      flags_q      <= '0;
    end else begin
      if (accept) begin
        opa_q        <= gnt_idx ? req_opa[2*WIDTH-1:WIDTH] : req_opa[WIDTH-1:0];
        opb_q        <= gnt_idx ? req_opb[2*WIDTH-1:WIDTH] : req_opb[WIDTH-1:0];
        cmd_q        <= gnt_idx ? req_cmd[2*CMD_WIDTH-1:CMD_WIDTH] : req_cmd[CMD_WIDTH-1:0];
        mode_q       <= req_mode[gnt_idx];
        cin_q        <= req_cin[gnt_idx];
        id_q         <= gnt_idx;
        last_grant_q <= gnt_idx;
      end
      if (state_q == S_ISSUE) begin
        cnt_q <= lat_load;
      end else if (state_q == S_WAIT) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (capture) begin
        res_q   <= alu_res;
        flags_q <= alu_flags;
      end
    end
  end

  assign alu_opa       = opa_q;
  assign alu_opb       = opb_q;
  assign alu_cmd       = cmd_q;
  assign alu_mode      = mode_q;
  assign alu_cin       = cin_q;
  assign alu_ce        = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign alu_inp_valid = (state_q == S_ISSUE) ? 2'b11 : 2'b00;

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = id_q;
  assign rsp_res   = res_q;
  assign rsp_flags = flags_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Directed bench for alu_req_scheduler. A small ALU model answers with the
// correct result only once the command's latency has elapsed since the issue
// edge, and returns a poison value before that.
module tb_alu_req_scheduler;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CW    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [2*WIDTH-1:0] req_opa, req_opb;
  logic [2*CW-1:0]  req_cmd;
  logic [1:0]       req_mode, req_cin;
  logic             rsp_valid, rsp_ready, rsp_id;
  logic [WIDTH:0]   rsp_res;
  logic [5:0]       rsp_flags;
  logic [WIDTH-1:0] alu_opa, alu_opb;
  logic [CW-1:0]    alu_cmd;
  logic             alu_mode, alu_cin, alu_ce;
  logic [1:0]       alu_inp_valid;
  logic [WIDTH:0]   alu_res;
  logic [5:0]       alu_flags;
  logic             busy;

  int n_vec = 0;
  int n_err = 0;

  alu_req_scheduler #(
    .WIDTH(8), .CMD_WIDTH(4), .LAT(1), .LAT_MUL(2), .MUL_CMD_A(9), .MUL_CMD_B(10)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opa(req_opa), .req_opb(req_opb), .req_cmd(req_cmd),
    .req_mode(req_mode), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_res(rsp_res), .rsp_flags(rsp_flags),
    .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_cmd(alu_cmd),
    .alu_mode(alu_mode), .alu_cin(alu_cin), .alu_ce(alu_ce),
    .alu_inp_valid(alu_inp_valid), .alu_res(alu_res), .alu_flags(alu_flags),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // ALU model: cmd 0 in arithmetic mode adds with carry-in, cmd 9/10 in
  // arithmetic mode multiply, anything else is a bitwise AND.
  int             age = 0;
  logic           m_mul;
  logic [WIDTH:0] m_res;
  int             m_lat;

  always @(posedge clk) begin
    if (alu_inp_valid == 2'b11) age <= 1;
    else if (!alu_ce)           age <= 0;
    else if (age < 1000)        age <= age + 1;
  end

  always_comb begin
    m_mul = alu_mode && (alu_cmd == 4'd9 || alu_cmd == 4'd10);
    m_lat = m_mul ? 2 : 1;
    if (m_mul)                           m_res = (WIDTH+1)'({1'b0, alu_opa} * {1'b0, alu_opb});
    else if (alu_mode && alu_cmd == '0)  m_res = {1'b0, alu_opa} + {1'b0, alu_opb} + {8'd0, alu_cin};
    else                                 m_res = {1'b0, alu_opa & alu_opb};
    if (age >= m_lat) begin
      alu_res   = m_res;
      alu_flags = {1'b0, m_res[WIDTH], alu_opa > alu_opb, alu_opa < alu_opb,
                   alu_opa == alu_opb, 1'b0};
    end else begin
      alu_res   = 9'h1AA;
      alu_flags = 6'h3F;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] c, input logic m, input logic ci);
    if (i == 0) begin
      req_opa[7:0] = a; req_opb[7:0] = b; req_cmd[3:0] = c;
    end else begin
      req_opa[15:8] = a; req_opb[15:8] = b; req_cmd[7:4] = c;
    end
    req_mode[i] = m;
    req_cin[i]  = ci;
  endtask

  initial begin
    rst = 1'b0; req_valid = '0; req_opa = '0; req_opb = '0; req_cmd = '0;
    req_mode = '0; req_cin = '0; rsp_ready = 1'b0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_alu_ce", alu_ce, 0);
    chk("rst_inp_valid", alu_inp_valid, 0);
    chk("rst_rsp_res", rsp_res, 0);
    rst = 1'b1;

    // Single ADD from requester 0
    set_req(0, 8'h05, 8'h03, 4'd0, 1'b1, 1'b0);
    req_valid = 2'b01; rsp_ready = 1'b1; #1;
    chk("t1_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    chk("t1_issue_inp", alu_inp_valid, 2'b11);
    chk("t1_issue_ce", alu_ce, 1);
    chk("t1_issue_opa", alu_opa, 8'h05);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_wait_inp", alu_inp_valid, 2'b00);
    chk("t1_wait_rsp", rsp_valid, 0);
    tick();
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_id", rsp_id, 0);
    chk("t1_rsp_res", rsp_res, 9'h008);
    chk("t1_rsp_flags", rsp_flags, 6'b001000);
    chk("t1_resp_ce", alu_ce, 0);
    tick();
    chk("t1_idle_rsp", rsp_valid, 0);
    chk("t1_idle_busy", busy, 0);

    // Both requesters valid continuously after a fresh reset
    rst = 1'b0; #1; rst = 1'b1;
    set_req(0, 8'h10, 8'h01, 4'd0, 1'b1, 1'b0);
    set_req(1, 8'h20, 8'h02, 4'd0, 1'b1, 1'b0);
    req_valid = 2'b11; #1;
    for (int k = 0; k < 4; k++) begin
      chk("rr_ready", req_ready, (k % 2 == 1) ? 2'b10 : 2'b01);
      tick();
      chk("rr_issue_opa", alu_opa, (k % 2 == 1) ? 8'h20 : 8'h10);
      chk("rr_issue_inp", alu_inp_valid, 2'b11);
      tick(); tick();
      chk("rr_rsp_valid", rsp_valid, 1);
      chk("rr_rsp_id", rsp_id, k % 2);
      chk("rr_rsp_res", rsp_res, (k % 2 == 1) ? 9'h022 : 9'h011);
      tick();
    end
    req_valid = 2'b00;

    // Multiply from requester 1
    set_req(1, 8'h0F, 8'h02, 4'd9, 1'b1, 1'b0);
    set_req(0, 8'hFF, 8'hFF, 4'd9, 1'b1, 1'b0);
    req_valid = 2'b10; #1;
    chk("mul_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    chk("mul_issue_inp", alu_inp_valid, 2'b11);
    chk("mul_issue_cmd", alu_cmd, 4'd9);
    tick();
    chk("mul_wait1_inp", alu_inp_valid, 2'b00);
    chk("mul_wait1_rsp", rsp_valid, 0);
    tick();
    chk("mul_wait2_rsp", rsp_valid, 0);
    chk("mul_wait2_ce", alu_ce, 1);
    tick();
    chk("mul_rsp_valid", rsp_valid, 1);
    chk("mul_rsp_id", rsp_id, 1);
    chk("mul_rsp_res", rsp_res, 9'h01E);
    chk("mul_rsp_flags", rsp_flags, 6'b001000);
    tick();
    chk("mul_idle", busy, 0);

    // Response backpressure with requester 0 still asking
    rsp_ready = 1'b0;
    set_req(0, 8'h07, 8'h07, 4'd0, 1'b1, 1'b0);
    req_valid = 2'b01; #1;
    chk("bp_ready", req_ready, 2'b01);
    tick(); tick(); tick();
    set_req(0, 8'h30, 8'h01, 4'd0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_id", rsp_id, 0);
      chk("bp_rsp_res", rsp_res, 9'h00E);
      chk("bp_ready_low", req_ready, 2'b00);
      tick();
    end
    chk("bp_rsp_flags", rsp_flags, 6'b000010);
    rsp_ready = 1'b1; #1;
    chk("bp_still_resp", rsp_valid, 1);
    tick();
    chk("bp_after_hs_rsp", rsp_valid, 0);
    chk("bp_after_hs_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    chk("bp_next_opa", alu_opa, 8'h30);
    chk("bp_next_inp", alu_inp_valid, 2'b11);
    tick(); tick();
    chk("bp_next_res", rsp_res, 9'h031);
    tick();

    // Reset asserted mid-WAIT
    set_req(1, 8'h03, 8'h04, 4'd10, 1'b1, 1'b0);
    req_valid = 2'b10; #1;
    tick();
    req_valid = 2'b00;
    tick();
    chk("rw_in_wait", alu_ce, 1);
    rst = 1'b0; #1;
    chk("rw_busy", busy, 0);
    chk("rw_alu_ce", alu_ce, 0);
    chk("rw_rsp_valid", rsp_valid, 0);
    set_req(0, 8'h01, 8'h01, 4'd0, 1'b1, 1'b0);
    req_valid = 2'b11; #1;
    chk("rw_ready_in_rst", req_ready, 2'b00);
    tick();
    rst = 1'b1; #1;
    chk("rw_ready_after", req_ready, 2'b01);
    chk("rw_no_stale", rsp_valid, 0);
    tick();
    req_valid = 2'b00;
    chk("rw_issue_rsp", rsp_valid, 0);
    chk("rw_issue_opa", alu_opa, 8'h01);
    tick();
    chk("rw_wait_rsp", rsp_valid, 0);
    tick();
    chk("rw_rsp_id", rsp_id, 0);
    chk("rw_rsp_res", rsp_res, 9'h002);
    tick();

    // Requester 0 valid for one cycle, then requester 1 only
    set_req(0, 8'h02, 8'h01, 4'd0, 1'b1, 1'b0);
    set_req(1, 8'h04, 8'h04, 4'd0, 1'b1, 1'b1);
    req_valid = 2'b01; #1;
    chk("sw_ready0", req_ready, 2'b01);
    tick();
    req_valid = 2'b10; #1;
    for (int k = 0; k < 3; k++) begin
      chk("sw_ready_busy", req_ready, 2'b00);
      if (k < 2) tick();
    end
    chk("sw_rsp0_id", rsp_id, 0);
    chk("sw_rsp0_res", rsp_res, 9'h003);
    tick();
    chk("sw_ready1", req_ready, 2'b10);
    tick();
    req_valid = 2'b11; #1;
    chk("sw_ready_none", req_ready, 2'b00);
    tick(); tick();
    chk("sw_rsp1_id", rsp_id, 1);
    chk("sw_rsp1_res", rsp_res, 9'h009);
    chk("sw_rsp1_flags", rsp_flags, 6'b000010);
    tick();
    chk("sw_next_grant0", req_ready, 2'b01);
    req_valid = 2'b00;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
